hcsr04_multi_driver: RTL
========================

Name: hcsr04_multi_driver

Overview:
Multi-channel HC-SR04 ultrasonic ranging controller. It time-multiplexes one measurement engine over NUM_CH sensors in round-robin order, skipping disabled channels. It supports continuous and single-sweep modes, flags timeouts, and keeps a per-channel proximity flag. It sits between the sensor pins and the application logic, and emits one tagged result per serviced channel.

Parameters:
NUM_CH, 4, number of sensors (1..16)
TRIG_CYCLES, 10, trigger pulse width in clk cycles
TIMEOUT_CYCLES, 25000, max cycles for rise wait and for echo width
SAMPLING_CYCLES, 60000, frame length per channel, counted from trigger start; must exceed TRIG_CYCLES+2*TIMEOUT_CYCLES+4
TOF_W, $clog2(TIMEOUT_CYCLES+1), result width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
en  in  1  continuous-mode run enable
mode  in  1  0=continuous, 1=single sweep
start  in  1  single-sweep start pulse (mode=1 only)
ch_en  in  NUM_CH  per-channel enable mask
near_thresh  in  TOF_W  proximity threshold in cycles
echo  in  NUM_CH  raw asynchronous echo pins
trig  out  NUM_CH  trigger pins, one-hot or zero
busy  out  1  engine not in IDLE
data_valid  out  1  one-cycle result strobe
data_ch  out  $clog2(NUM_CH) (min 1)  channel of current result
tof  out  TOF_W  echo high width in cycles
timeout_err  out  1  result is a timeout
near  out  NUM_CH  sticky-until-next-result proximity flags

Behaviour:
- Reset (async, rst=0): all outputs 0; FSM IDLE; channel pointer 0; synchronisers cleared.
- Each echo bit passes a 2-flop synchroniser. Edges are detected on synced values only.
- States: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE → TRIG when there is a run request and ch_en != 0.
  - Run request: mode=0 with en=1, or mode=1 with start=1.
  - Selected channel is the first enabled channel at or after the pointer, with wrap-around, taken from ch_en sampled in that cycle.
  - Frame timer is cleared to 0.
- TRIG: trig[ch]=1 for exactly TRIG_CYCLES cycles, then → WAIT_RISE. Frame timer counts every cycle of the frame.
- WAIT_RISE: on a synced 0→1 on echo[ch] → MEASURE, width=1. An echo already high on entry is not a rise. If frame timer reaches TRIG_CYCLES+TIMEOUT_CYCLES, record a timeout → HOLDOFF.
- MEASURE: width increments each cycle echo_s is high.
  - Synced fall: record tof=width → HOLDOFF.
  - width reaches TIMEOUT_CYCLES with echo still high: record a timeout → HOLDOFF.
- Result is published on the first HOLDOFF cycle:
  - data_valid=1 for one cycle, data_ch=ch.
  - Normal result: tof=measured width, timeout_err=0.
  - Timeout: tof=0, timeout_err=1.
  - tof, data_ch and timeout_err hold until the next result.
- near[ch] is updated on the same cycle: 1 iff !timeout and tof < near_thresh, else 0. Other near bits are unchanged.
- HOLDOFF ends when frame timer == SAMPLING_CYCLES-1. The pointer then advances to ch+1 (mod NUM_CH).
  - mode=0, en=1, ch_en!=0: go directly to TRIG of the next enabled channel, with no IDLE cycle.
  - mode=1: continue while the sweep has enabled channels left. Sweep = channels enabled at start time, in index order from 0. Otherwise → IDLE.
  - Otherwise → IDLE.
- Latency: data_valid is high 3 clk after the first clk edge that samples echo low.
- en or mode changes mid-frame: the current frame completes and its result is published. The change is evaluated at the frame end.
- start while busy: ignored.
- ch_en=0: stay IDLE, busy=0, start ignored.
- ch_en changes mid-frame: affects only the next selection.
- Echo glitches on non-selected channels: ignored.
- busy=1 in every state except IDLE.
- tof never exceeds TIMEOUT_CYCLES-1 for a valid result. Counters saturate and never wrap within a frame.

Test Plan:
Bench parameters for all scenarios: NUM_CH=2, TRIG=10, TIMEOUT=200, SAMPLING=500.
1. mode=0, en=1, ch_en=2'b01; echo[0] high 120 cycles starting 30 cycles after trig falls → trig[0] high exactly 10 cycles; data_valid once per 500 cycles; data_ch=0, tof=120, timeout_err=0.
2. echo[0] never rises → data_valid at frame cycle 211 (timer hits 210, publish next); tof=0, timeout_err=1, near[0]=0.
3. echo[0] stuck high for 300 cycles after rise → timeout_err=1, tof=0; next frame echo already high at entry produces a rise-timeout, not a measurement.
4. ch_en=2'b11, echo widths 50 on ch0 and 150 on ch1, near_thresh=100 → alternating data_ch 0,1,0,1 every 500 cycles; near=2'b01.
5. mode=1, ch_en=2'b11, one start pulse → exactly two results (ch0, then ch1), then busy=0; second start during the sweep is ignored.
6. rst pulled low mid-MEASURE → all outputs 0 asynchronously, same cycle; after release the first result comes from ch0.

Source files
------------

// File: rtl/hcsr04_multi_driver.sv
// Multi-channel HC-SR04 ranging controller: one trigger/measure engine shared
// round-robin over NUM_CH sensors, with continuous and single-sweep operation,
// timeout reporting and a per-channel proximity flag.
module hcsr04_multi_driver #(
  parameter int NUM_CH          = 4,
  parameter int TRIG_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES  = 25000,
  parameter int SAMPLING_CYCLES = 60000,
  parameter int TOF_W           = $clog2(TIMEOUT_CYCLES + 1),
  parameter int CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              mode_i,
  input  logic              start_i,
  input  logic [NUM_CH-1:0] ch_en_i,
  input  logic [TOF_W-1:0]  near_thresh_i,
  input  logic [NUM_CH-1:0] echo_i,
  output logic [NUM_CH-1:0] trig_o,
  output logic              busy_o,
  output logic              data_valid_o,
  output logic [CH_W-1:0]   data_ch_o,
  output logic [TOF_W-1:0]  tof_o,
  output logic              timeout_err_o,
  output logic [NUM_CH-1:0] near_o
);

  localparam int TMR_W = $clog2(SAMPLING_CYCLES);
  localparam logic [TMR_W-1:0] TRIG_LAST  = TMR_W'(TRIG_CYCLES - 1);
  localparam logic [TMR_W-1:0] RISE_LIMIT = TMR_W'(TRIG_CYCLES + TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] FRAME_LAST = TMR_W'(SAMPLING_CYCLES - 1);
  localparam logic [TOF_W-1:0] WIDTH_LAST = TOF_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_HOLDOFF
  } state_t;

  state_t            state_q;
  logic [CH_W-1:0]   ch_q;
  logic [CH_W-1:0]   ptr_q;
  logic [TMR_W-1:0]  timer_q;
  logic [TOF_W-1:0]  width_q;
  logic [NUM_CH-1:0] sweep_q;
  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;
  logic              echo_sel_q;
  logic              echo_prev_q;

  logic [NUM_CH-1:0] trig_q;
  logic              busy_q;
  logic              data_valid_q;
  logic [CH_W-1:0]   data_ch_q;
  logic [TOF_W-1:0]  tof_q;
  logic              timeout_err_q;
  logic [NUM_CH-1:0] near_q;

  logic              rise;
  logic [CH_W-1:0]   next_ptr;
  logic [CH_W-1:0]   base_ptr;
  logic [CH_W-1:0]   idx;
  logic [CH_W-1:0]   cont_ch;
  logic [CH_W-1:0]   first_ch;
  logic [CH_W-1:0]   sweep_ch;
  logic              cont_ok;
  logic              sweep_ok;
  logic              run_req;
  logic              pub;
  logic              pub_to;
  logic [TOF_W-1:0]  pub_tof;
  logic              launch;
  logic [CH_W-1:0]   launch_ch;
  logic [NUM_CH-1:0] launch_sweep;

  // Two-flop synchroniser on every echo pin, then the selected channel is
  // registered after the mux and delayed once more for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      echo_sel_q  <= 1'b0;
      echo_prev_q <= 1'b0;
    end else begin
      sync1_q     <= echo_i;
      sync2_q     <= sync1_q;
      echo_sel_q  <= sync2_q[ch_q];
      echo_prev_q <= echo_sel_q;
    end
  end

  // A level that is already high when the engine starts listening has
  // echo_prev_q set too, so it never counts as a rise.
  assign rise = echo_sel_q & ~echo_prev_q;

  // Channel selection: round-robin from the pointer, lowest-first for a new
  // sweep, and the next remaining channel of a sweep in progress.
  always_comb begin
    next_ptr = (int'(ch_q) == NUM_CH - 1) ? '0 : ch_q + CH_W'(1);
    base_ptr = (state_q == ST_HOLDOFF) ? next_ptr : ptr_q;
    idx      = '0;
    cont_ok  = 1'b0;
    cont_ch  = '0;
    first_ch = '0;
    sweep_ok = 1'b0;
    sweep_ch = '0;
    // Descending scan so the lowest offset / index is the last one written.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = CH_W'((int'(base_ptr) + k) % NUM_CH);
      if (ch_en_i[idx]) begin
        cont_ok = 1'b1;
        cont_ch = idx;
      end
      if (ch_en_i[k]) begin
        first_ch = CH_W'(k);
      end
      if (sweep_q[k] && (k > int'(ch_q))) begin
        sweep_ok = 1'b1;
        sweep_ch = CH_W'(k);
      end
    end
  end

  // Decide when a result is published and when a new frame is launched.
  always_comb begin
    run_req      = mode_i ? start_i : en_i;
    pub          = 1'b0;
    pub_to       = 1'b0;
    pub_tof      = '0;
    launch       = 1'b0;
    launch_ch    = '0;
    launch_sweep = '0;
    case (state_q)
      ST_IDLE: begin
        if (run_req && (|ch_en_i)) begin
          launch = 1'b1;
          if (mode_i) begin
            launch_ch    = first_ch;
            launch_sweep = ch_en_i;
          end else begin
            launch_ch = cont_ch;
          end
        end
      end
      ST_WAIT_RISE: begin
        if (!rise && (timer_q == RISE_LIMIT)) begin
          pub    = 1'b1;
          pub_to = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (!echo_sel_q) begin
          pub     = 1'b1;
          pub_tof = width_q;
        end else if (width_q == WIDTH_LAST) begin
          pub    = 1'b1;
          pub_to = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (timer_q == FRAME_LAST) begin
          if (!mode_i && en_i && cont_ok) begin
            launch    = 1'b1;
            launch_ch = cont_ch;
          end else if (mode_i && sweep_ok) begin
            launch       = 1'b1;
            launch_ch    = sweep_ch;
            launch_sweep = sweep_q;
          end
        end
      end
      default: ;
    endcase
  end

  // Measurement engine FSM with registered pin and result outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      ch_q          <= '0;
      ptr_q         <= '0;
      timer_q       <= '0;
      width_q       <= '0;
      sweep_q       <= '0;
      trig_q        <= '0;
      busy_q        <= 1'b0;
      data_valid_q  <= 1'b0;
      data_ch_q     <= '0;
      tof_q         <= '0;
      timeout_err_q <= 1'b0;
      near_q        <= '0;
    end else begin
      data_valid_q <= 1'b0;
      // Frame timer saturates at the last frame cycle instead of wrapping.
      if (timer_q != FRAME_LAST) begin
        timer_q <= timer_q + TMR_W'(1);
      end
      case (state_q)
        ST_TRIG: begin
          if (timer_q == TRIG_LAST) begin
            trig_q  <= '0;
            state_q <= ST_WAIT_RISE;
          end
        end
        ST_WAIT_RISE: begin
          if (rise) begin
            width_q <= TOF_W'(1);
            state_q <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (echo_sel_q && (width_q != WIDTH_LAST)) begin
            width_q <= width_q + TOF_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (timer_q == FRAME_LAST) begin
            ptr_q   <= next_ptr;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
      if (pub) begin
        state_q       <= ST_HOLDOFF;
        data_valid_q  <= 1'b1;
        data_ch_q     <= ch_q;
        tof_q         <= pub_tof;
        timeout_err_q <= pub_to;
        near_q[ch_q]  <= !pub_to && (pub_tof < near_thresh_i);
      end
      // A launch out of HOLDOFF overrides the drop to IDLE above.
      if (launch) begin
        state_q <= ST_TRIG;
        busy_q  <= 1'b1;
        ch_q    <= launch_ch;
        sweep_q <= launch_sweep;
        timer_q <= '0;
        trig_q  <= NUM_CH'(1) << launch_ch;
      end
    end
  end

  assign trig_o        = trig_q;
  assign busy_o        = busy_q;
  assign data_valid_o  = data_valid_q;
  assign data_ch_o     = data_ch_q;
  assign tof_o         = tof_q;
  assign timeout_err_o = timeout_err_q;
  assign near_o        = near_q;

endmodule
